// File: rtl/blowfish128_pkg.sv
// Shared types and key-pair helpers for the Blowfish-128 cores.
// No logic of its own; imported by the decrypt core and its key selector.
package blowfish128_pkg;

    localparam int NUM_KEYPAIRS = 10;
    localparam int HALF_W       = 64;

    typedef logic [HALF_W-1:0]              half_t;
    typedef logic [NUM_KEYPAIRS*HALF_W-1:0] key_array_t;

    typedef enum logic [2:0] {
        DEC_IDLE,
        DEC_LOAD,
        DEC_REQ,
        DEC_REL,
        DEC_FINAL,
        DEC_DONE
    } dec_step_t;

    // K[i] lives at bits [i*64 +: 64]; constant-index loop keeps the select width-clean.
    function automatic half_t key_pair(input key_array_t keys, input logic [3:0] idx);
        half_t k;
        k = '0;
        for (int i = 0; i < NUM_KEYPAIRS; i++) begin
            if (idx == 4'(i)) begin
                k = keys[i*HALF_W +: HALF_W];
            end
        end
        return k;
    endfunction

endpackage

// File: rtl/blowfish128_dec_keysel.sv
// Round-key selector: K[9-rnd] (or K[rnd+2] when ASCENDING) plus whitening keys K0, K1.
// Latency: combinational.
// Backpressure: none; pure mux.
module blowfish128_dec_keysel
    import blowfish128_pkg::*;
#(
    parameter bit ASCENDING = 1'b0
) (
    input  logic [31:0] P1,
    input  logic [31:0] P2,
    input  logic [31:0] P3,
    input  logic [31:0] P4,
    input  logic [31:0] P5,
    input  logic [31:0] P6,
    input  logic [31:0] P7,
    input  logic [31:0] P8,
    input  logic [31:0] P9,
    input  logic [31:0] P10,
    input  logic [31:0] P11,
    input  logic [31:0] P12,
    input  logic [31:0] P13,
    input  logic [31:0] P14,
    input  logic [31:0] P15,
    input  logic [31:0] P16,
    input  logic [31:0] P17,
    input  logic [31:0] P18,
    input  logic [31:0] P19,
    input  logic [31:0] P20,
    input  logic [3:0]  rnd,
    output logic [63:0] k_round,
    output logic [63:0] k0,
    output logic [63:0] k1
);

    key_array_t keys;
    logic [3:0] idx;

    // Odd-numbered P word is the high half of each pair.
    assign keys = {P19, P20, P17, P18, P15, P16, P13, P14, P11, P12,
                   P9,  P10, P7,  P8,  P5,  P6,  P3,  P4,  P1,  P2};

    assign idx     = ASCENDING ? (rnd + 4'd2) : (4'd9 - rnd);
    assign k_round = key_pair(keys, idx);
    assign k0      = key_pair(keys, 4'd0);
    assign k1      = key_pair(keys, 4'd1);

endmodule

// File: rtl/blowfish128_decrypt_core.sv
// Blowfish-128 decrypt: 8 Feistel rounds on 64-bit halves, keys K9..K2, then whitening with K0/K1.
// Latency: 1 LOAD + 3 cycles/round with a 1-cycle ffunc + 1 FINAL; ffunc stalls stretch REQ/REL.
// Backpressure: waits on ffunc_ready level handshake; BLOWFISH128_DEC_OUTMASK_EN zeroes plainText until done.
module blowfish128_decrypt_core
    import blowfish128_pkg::*;
#(
    parameter int NUM_ROUNDS = 8
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         Enable,
    input  logic [127:0] cipherText,
    output logic [127:0] plainText,
    output logic         plainReady,
    input  logic         skey_ready,
    input  logic [31:0]  P1,
    input  logic [31:0]  P2,
    input  logic [31:0]  P3,
    input  logic [31:0]  P4,
    input  logic [31:0]  P5,
    input  logic [31:0]  P6,
    input  logic [31:0]  P7,
    input  logic [31:0]  P8,
    input  logic [31:0]  P9,
    input  logic [31:0]  P10,
    input  logic [31:0]  P11,
    input  logic [31:0]  P12,
    input  logic [31:0]  P13,
    input  logic [31:0]  P14,
    input  logic [31:0]  P15,
    input  logic [31:0]  P16,
    input  logic [31:0]  P17,
    input  logic [31:0]  P18,
    input  logic [31:0]  P19,
    input  logic [31:0]  P20,
    input  logic [63:0]  Y,
    input  logic         ffunc_ready,
    output logic [63:0]  X,
    output logic         ffunc_enable
);

    generate
        if (NUM_ROUNDS != 8) begin : g_bad_rounds
            $error("blowfish128_decrypt_core: NUM_ROUNDS must be 8 (20-word P-array)");
        end
    endgenerate

    localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

    dec_step_t  state;
    half_t      l_half;
    half_t      r_half;
    logic [3:0] rnd;
    half_t      k_round;
    half_t      k0;
    half_t      k1;
    logic       abort;

    blowfish128_dec_keysel #(.ASCENDING(1'b0)) u_keysel (
        .P1 (P1),  .P2 (P2),  .P3 (P3),  .P4 (P4),  .P5 (P5),
        .P6 (P6),  .P7 (P7),  .P8 (P8),  .P9 (P9),  .P10(P10),
        .P11(P11), .P12(P12), .P13(P13), .P14(P14), .P15(P15),
        .P16(P16), .P17(P17), .P18(P18), .P19(P19), .P20(P20),
        .rnd    (rnd),
        .k_round(k_round),
        .k0     (k0),
        .k1     (k1)
    );

    // Losing the key schedule only matters while the key is actually in use.
    assign abort = !Enable ||
                   (!skey_ready && (state inside {DEC_LOAD, DEC_REQ, DEC_REL, DEC_FINAL}));

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state        <= DEC_IDLE;
            l_half       <= '0;
            r_half       <= '0;
            rnd          <= '0;
            X            <= '0;
            ffunc_enable <= 1'b0;
            plainReady   <= 1'b0;
        end else if (abort) begin
            state        <= DEC_IDLE;
            l_half       <= '0;
            r_half       <= '0;
            rnd          <= '0;
            X            <= '0;
            ffunc_enable <= 1'b0;
            plainReady   <= 1'b0;
        end else begin
            case (state)
                DEC_IDLE: begin
                    if (skey_ready) begin
                        state <= DEC_LOAD;
                    end
                end
                DEC_LOAD: begin
                    l_half <= cipherText[127:64];
                    r_half <= cipherText[63:0];
                    rnd    <= '0;
                    state  <= DEC_REQ;
                end
                DEC_REQ: begin
                    // X already holds L ^ Kr, so it doubles as the new R.
                    if (!ffunc_enable) begin
                        X            <= l_half ^ k_round;
                        ffunc_enable <= 1'b1;
                    end else if (ffunc_ready) begin
                        l_half       <= r_half ^ Y;
                        r_half       <= X;
                        ffunc_enable <= 1'b0;
                        rnd          <= rnd + 4'd1;
                        state        <= DEC_REL;
                    end
                end
                DEC_REL: begin
                    if (!ffunc_ready) begin
                        state <= (rnd < LAST_RND) ? DEC_REQ : DEC_FINAL;
                    end
                end
                DEC_FINAL: begin
                    l_half     <= r_half ^ k0;
                    r_half     <= l_half ^ k1;
                    plainReady <= 1'b1;
                    state      <= DEC_DONE;
                end
                DEC_DONE: begin
                    plainReady <= 1'b1;
                end
                default: begin
                    state <= DEC_IDLE;
                end
            endcase
        end
    end

`ifdef BLOWFISH128_DEC_OUTMASK_EN
    assign plainText = plainReady ? {l_half, r_half} : 128'h0;
`else
    assign plainText = {l_half, r_half};
`endif

endmodule

// File: tb/tb_blowfish128_decrypt_core.sv
// Directed + randomized bench: round-trips random plaintexts through a behavioural encrypt model.
module tb_blowfish128_decrypt_core;

    logic         Clk;
    logic         Rst;
    logic         Enable;
    logic [127:0] cipherText;
    logic [127:0] plainText;
    logic         plainReady;
    logic         skey_ready;
    logic [31:0]  p [1:20];
    logic [63:0]  Y;
    logic         ffunc_ready;
    logic [63:0]  X;
    logic         ffunc_enable;

    int checks = 0;
    int failures = 0;

    bit          fmode = 1'b1;
    int          extra_hold = 0;
    int          hold = 0;
    logic        prev_en = 1'b0;
    logic [63:0] first_x = '0;
    int          req_cnt = 0;
    int          x_viol = 0;
    logic [63:0] x_log [$];

    blowfish128_decrypt_core dut (
        .Clk(Clk), .Rst(Rst), .Enable(Enable),
        .cipherText(cipherText), .plainText(plainText), .plainReady(plainReady),
        .skey_ready(skey_ready),
        .P1 (p[1]),  .P2 (p[2]),  .P3 (p[3]),  .P4 (p[4]),  .P5 (p[5]),
        .P6 (p[6]),  .P7 (p[7]),  .P8 (p[8]),  .P9 (p[9]),  .P10(p[10]),
        .P11(p[11]), .P12(p[12]), .P13(p[13]), .P14(p[14]), .P15(p[15]),
        .P16(p[16]), .P17(p[17]), .P18(p[18]), .P19(p[19]), .P20(p[20]),
        .Y(Y), .ffunc_ready(ffunc_ready), .X(X), .ffunc_enable(ffunc_enable)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Stand-in F-function: any fixed nonlinear map works since Feistel only needs F to be a function.
    function automatic logic [63:0] f_ref(input logic [63:0] x);
        logic [31:0] a, b;
        a = x[63:32];
        b = x[31:0];
        return {(a * 32'h9E37_79B1) ^ {b[20:0], b[31:21]},
                (b + 32'h7F4A_7C15) ^ {a[7:0], a[31:8]}};
    endfunction

    assign Y = fmode ? f_ref(X) : 64'h0;

    function automatic logic [63:0] kp(input int i);
        return {p[2*i+1], p[2*i+2]};
    endfunction

    // Encrypt model: inverse of the decrypt rules, walking rounds K2..K9 upward.
    function automatic logic [127:0] enc_ref(input logic [127:0] pt);
        logic [63:0] l, r, x;
        l = pt[63:0]   ^ kp(1);
        r = pt[127:64] ^ kp(0);
        for (int j = 2; j <= 9; j++) begin
            x = r;
            r = l ^ (fmode ? f_ref(x) : 64'h0);
            l = x ^ kp(j);
        end
        return {l, r};
    endfunction

    // ffunc responder: ready follows enable half a cycle later, optionally held high longer.
    always @(negedge Clk) begin
        if (ffunc_enable) begin
            if (!prev_en) begin
                req_cnt++;
                x_log.push_back(X);
                first_x = X;
            end else if (X !== first_x) begin
                x_viol++;
            end
            ffunc_ready = 1'b1;
            hold = extra_hold;
        end else if (hold > 0) begin
            hold--;
        end else begin
            ffunc_ready = 1'b0;
        end
        prev_en = ffunc_enable;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_dec(input logic [127:0] ct, output logic [127:0] pt,
                           output int cyc, output logic rdy);
        @(posedge Clk);
        #1;
        cipherText = ct;
        Enable = 1'b1;
        cyc = 0;
        rdy = 1'b0;
        while (!rdy && cyc < 3000) begin
            @(posedge Clk);
            #1;
            cyc++;
            rdy = plainReady;
        end
        pt = plainText;
    endtask

    task automatic release_dec();
        Enable = 1'b0;
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_log();
        req_cnt = 0;
        x_viol = 0;
        x_log.delete();
    endtask

    initial begin
        logic [127:0] pt, ct, res;
        int           cyc;
        logic         rdy;
        int           waited;

        Rst = 1'b1;
        Enable = 1'b0;
        skey_ready = 1'b1;
        cipherText = '0;
        ffunc_ready = 1'b0;
        for (int n = 1; n <= 20; n++) p[n] = '0;

        #12;
        check("reset_plainReady", 128'(plainReady), 128'd0);
        check("reset_plainText", plainText, 128'h0);
        check("reset_X", 128'(X), 128'h0);
        check("reset_ffunc_enable", 128'(ffunc_enable), 128'd0);
        Rst = 1'b0;

        // Swap check: zero keys and zero F reduce decrypt to a half swap.
        fmode = 1'b0;
        clear_log();
        run_dec(128'h0123456789ABCDEF_FEDCBA9876543210, res, cyc, rdy);
        check("swap_ready", 128'(rdy), 128'd1);
        check("swap_plain", res, 128'hFEDCBA9876543210_0123456789ABCDEF);
        check("swap_latency", 128'(cyc), 128'd27);
        check("swap_requests", 128'(req_cnt), 128'd8);
        repeat (3) @(posedge Clk);
        #1;
        check("done_hold_ready", 128'(plainReady), 128'd1);
        check("done_hold_plain", plainText, 128'hFEDCBA9876543210_0123456789ABCDEF);
        release_dec();
        check("done_release_ready", 128'(plainReady), 128'd0);

        // Key order: first three F inputs expose the descending key schedule.
        for (int n = 1; n <= 20; n++) p[n] = 32'(n);
        clear_log();
        run_dec(128'h0, res, cyc, rdy);
        check("keyord_requests", 128'(x_log.size()), 128'd8);
        if (x_log.size() >= 3) begin
            check("keyord_x0", 128'(x_log[0]), 128'h00000013_00000014);
            check("keyord_x1", 128'(x_log[1]), 128'(kp(8)));
            check("keyord_x2", 128'(x_log[2]), 128'(kp(9) ^ kp(7)));
        end
        release_dec();

        // Round trips with random keys and plaintexts through the encrypt model.
        fmode = 1'b1;
        for (int t = 0; t < 5; t++) begin
            for (int n = 1; n <= 20; n++) p[n] = $urandom;
            pt = (t == 0) ? 128'hDEADBEEF_CAFEBABE_00112233_44556677
                          : {$urandom, $urandom, $urandom, $urandom};
            ct = enc_ref(pt);
            clear_log();
            run_dec(ct, res, cyc, rdy);
            check($sformatf("roundtrip_%0d", t), res, pt);
            check($sformatf("roundtrip_req_%0d", t), 128'(req_cnt), 128'd8);
            release_dec();
        end

        // Handshake: ready held 5 extra cycles must not double-count rounds.
        extra_hold = 5;
        pt = {$urandom, $urandom, $urandom, $urandom};
        ct = enc_ref(pt);
        clear_log();
        run_dec(ct, res, cyc, rdy);
        check("hs_plain", res, pt);
        check("hs_requests", 128'(req_cnt), 128'd8);
        check("hs_x_stable", 128'(x_viol), 128'd0);
        release_dec();
        extra_hold = 0;

        // Abort during round 4, then a clean re-run.
        pt = {$urandom, $urandom, $urandom, $urandom};
        ct = enc_ref(pt);
        clear_log();
        @(posedge Clk);
        #1;
        cipherText = ct;
        Enable = 1'b1;
        waited = 0;
        while (req_cnt < 4 && waited < 500) begin
            @(posedge Clk);
            #1;
            waited++;
        end
        check("abort_reached_round4", 128'(req_cnt), 128'd4);
        Enable = 1'b0;
        @(posedge Clk);
        #1;
        check("abort_ffunc_enable", 128'(ffunc_enable), 128'd0);
        check("abort_plainReady", 128'(plainReady), 128'd0);
        check("abort_plainText", plainText, 128'h0);
        clear_log();
        run_dec(ct, res, cyc, rdy);
        check("abort_rerun_plain", res, pt);
        release_dec();

        // Async reset mid-REQ, between clock edges.
        pt = {$urandom, $urandom, $urandom, $urandom};
        ct = enc_ref(pt);
        @(posedge Clk);
        #1;
        cipherText = ct;
        Enable = 1'b1;
        waited = 0;
        while (!ffunc_enable && waited < 200) begin
            @(negedge Clk);
            waited++;
        end
        check("rst_saw_request", 128'(ffunc_enable), 128'd1);
        #1;
        Rst = 1'b1;
        skey_ready = 1'b0;
        #1;
        check("rst_async_X", 128'(X), 128'h0);
        check("rst_async_ffunc_enable", 128'(ffunc_enable), 128'd0);
        check("rst_async_plainText", plainText, 128'h0);
        check("rst_async_plainReady", 128'(plainReady), 128'd0);
        #1;
        Rst = 1'b0;
        clear_log();
        repeat (30) @(posedge Clk);
        #1;
        check("nokey_requests", 128'(req_cnt), 128'd0);
        check("nokey_plainReady", 128'(plainReady), 128'd0);
        Enable = 1'b0;
        skey_ready = 1'b1;
        repeat (2) @(posedge Clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
